// File: rtl/cache_fill_fsm.sv
// Miss-handling controller between one cache and shared main memory: on a granted miss it
// streams one read per word of the block, writes each returned word, then pulses the tag write.
//
// state | meaning
// IDLE  | no fill in progress; waits for miss_detected & mem_grant
// FILL  | issuing block reads and collecting returns for the latched base
module cache_fill_fsm #(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              mem_grant,
   input  logic              memory_data_valid,
   input  logic [DATA_W-1:0] memory_data_in,
   output logic              fsm_busy,
   output logic              mem_enable,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [ADDR_W-1:0] write_word_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              write_tag_array
);

   localparam int WIDX_W = $clog2(WORDS_PER_BLOCK);
   localparam int CNT_W  = WIDX_W + 1;
   localparam int OFF_W  = WIDX_W + 1;
   localparam logic [CNT_W-1:0]  WPB      = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

   // Offset is ORed into the block-aligned base and masked, so an address never carries out of its block.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [CNT_W-1:0]  idx);
      return b | ((ADDR_W'(idx) << 1) & OFF_MASK);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      issue_cnt_d      = issue_cnt_q;
      recv_cnt_d       = recv_cnt_q;
      fsm_busy         = 1'b0;
      mem_enable       = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      write_word_addr  = '0;
      write_data       = '0;
      write_tag_array  = 1'b0;

      case (state_q)
         IDLE: begin
            if (miss_detected && mem_grant) begin
               state_d     = FILL;
               base_d      = miss_address & ~OFF_MASK;
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
            end
         end
         FILL: begin
            fsm_busy       = 1'b1;
            mem_enable     = (issue_cnt_q < WPB);
            memory_address = word_addr(base_q, issue_cnt_q);
            if (mem_enable) issue_cnt_d = issue_cnt_q + 1'b1;

            write_data_array = memory_data_valid && (recv_cnt_q < WPB);
            write_word_addr  = word_addr(base_q, recv_cnt_q);
            write_data       = memory_data_in;
            if (write_data_array) recv_cnt_d = recv_cnt_q + 1'b1;

            // Returns are counted, not timed: the last accepted word closes the fill.
            write_tag_array = write_data_array && (recv_cnt_q == LAST);
            if (write_tag_array) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
